// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel prescaler, horizontal/vertical counters,
// registered sync/visible decode, start pulses and a pixel-aligned delay
// line for the sync and video-enable outputs.
module vga_sync_gen #(
    parameter int   H_VIS   = 640,
    parameter int   H_FP    = 16,
    parameter int   H_SYNC  = 96,
    parameter int   H_BP    = 48,
    parameter int   V_VIS   = 480,
    parameter int   V_FP    = 10,
    parameter int   V_SYNC  = 2,
    parameter int   V_BP    = 33,
    parameter int   CLK_DIV = 4,
    parameter logic HS_POL  = 1'b0,
    parameter logic VS_POL  = 1'b0,
    parameter int   CW      = 10,
    parameter int   DLY     = 2
) (
    input  logic          reloj,
    input  logic          resetM,
    input  logic          enable,
    output logic [CW-1:0] Qh,
    output logic [CW-1:0] Qv,
    output logic          H_Sync,
    output logic          V_Sync,
    output logic          H_ON,
    output logic          V_ON,
    output logic          pix_tick,
    output logic          line_start,
    output logic          frame_start,
    output logic          H_Sync2,
    output logic          V_Sync2,
    output logic          video_on2
);

    localparam int H_TOT   = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int H_SS    = H_VIS + H_FP;
    localparam int H_SE    = H_VIS + H_FP + H_SYNC - 1;
    localparam int V_SS    = V_VIS + V_FP;
    localparam int V_SE    = V_VIS + V_FP + V_SYNC - 1;

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOT - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOT - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [3:0]    PRESC_LAST = 4'(CLK_DIV - 1);

    // Parameter sanity: totals must fit the counter width.
    if (H_TOT > (1 << CW)) begin : g_bad_h_tot
        $fatal(1, "vga_sync_gen: H_TOT exceeds 2**CW");
    end
    if (V_TOT > (1 << CW)) begin : g_bad_v_tot
        $fatal(1, "vga_sync_gen: V_TOT exceeds 2**CW");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $fatal(1, "vga_sync_gen: CLK_DIV out of range 1..16");
    end
    if (DLY < 0 || DLY > 7) begin : g_bad_dly
        $fatal(1, "vga_sync_gen: DLY out of range 0..7");
    end

    logic [3:0]    presc_q, presc_d;
    logic [CW-1:0] qh_q, qh_d, qv_q, qv_d;
    logic          hs_q, hs_d, vs_q, vs_d, hon_q, hon_d, von_q, von_d;
    logic          ls_q, ls_d, fs_q, fs_d;
    logic          tick_s;

    // Pixel strobe; masked by reset so CLK_DIV=1 stays quiet while held in reset.
    assign tick_s = resetM & enable & (presc_q == PRESC_LAST);

    // Next-state: prescaler, counters, start pulses and decode of the new count.
    always_comb begin
        presc_d = presc_q;
        qh_d    = qh_q;
        qv_d    = qv_q;
        ls_d    = 1'b0;
        fs_d    = 1'b0;
        if (enable) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = 4'd0;
            end else begin
                presc_d = presc_q + 4'd1;
            end
        end else begin
            presc_d = presc_q;
        end
        if (tick_s) begin
            if (qh_q == H_LAST) begin
                qh_d = '0;
                ls_d = 1'b1;
                if (qv_q == V_LAST) begin
                    qv_d = '0;
                    fs_d = 1'b1;
                end else begin
                    qv_d = qv_q + CNT_ONE;
                end
            end else begin
                qh_d = qh_q + CNT_ONE;
            end
        end else begin
            qh_d = qh_q;
        end
        // Decode the count being loaded so flags change on the same edge.
        hon_d = (int'(qh_d) < H_VIS);
        von_d = (int'(qv_d) < V_VIS);
        hs_d  = ((int'(qh_d) >= H_SS) && (int'(qh_d) <= H_SE)) ? HS_POL : ~HS_POL;
        vs_d  = ((int'(qv_d) >= V_SS) && (int'(qv_d) <= V_SE)) ? VS_POL : ~VS_POL;
    end

    // Timing state registers with asynchronous reset to the top-left pixel.
    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            presc_q <= 4'd0;
            qh_q    <= '0;
            qv_q    <= '0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            hon_q   <= 1'b1;
            von_q   <= 1'b1;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            qh_q    <= qh_d;
            qv_q    <= qv_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            hon_q   <= hon_d;
            von_q   <= von_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign Qh          = qh_q;
    assign Qv          = qv_q;
    assign H_Sync      = hs_q;
    assign V_Sync      = vs_q;
    assign H_ON        = hon_q;
    assign V_ON        = von_q;
    assign pix_tick    = tick_s;
    // Pulses are suppressed while frozen.
    assign line_start  = ls_q & enable;
    assign frame_start = fs_q & enable;

    if (DLY == 0) begin : g_nodly
        assign H_Sync2   = hs_q;
        assign V_Sync2   = vs_q;
        assign video_on2 = hon_q & von_q;
    end else begin : g_dly
        logic [DLY-1:0] dh_q, dv_q, dvid_q;

        // Pixel-rate shift register; stage 0 captures the pre-tick levels.
        always_ff @(posedge reloj or negedge resetM) begin
            if (!resetM) begin
                dh_q   <= {DLY{~HS_POL}};
                dv_q   <= {DLY{~VS_POL}};
                dvid_q <= '0;
            end else if (tick_s) begin
                dh_q[0]   <= hs_q;
                dv_q[0]   <= vs_q;
                dvid_q[0] <= hon_q & von_q;
                for (int i = 1; i < DLY; i++) begin
                    dh_q[i]   <= dh_q[i-1];
                    dv_q[i]   <= dv_q[i-1];
                    dvid_q[i] <= dvid_q[i-1];
                end
            end else begin
                dh_q   <= dh_q;
                dv_q   <= dv_q;
                dvid_q <= dvid_q;
            end
        end

        assign H_Sync2   = dh_q[DLY-1];
        assign V_Sync2   = dv_q[DLY-1];
        assign video_on2 = dvid_q[DLY-1];
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance and a tiny fast instance
// are checked every cycle against an arithmetic model (pixel index derived
// from the number of enabled clocks), plus directed literal checks.
module tb_vga_sync_gen;

    typedef struct packed {
        int div; int hv; int hfp; int hs; int hbp;
        int vv;  int vfp; int vs; int vbp;
        bit hp;  bit vp; int dly;
    } cfg_t;

    localparam cfg_t CFG_A = '{div:4, hv:640, hfp:16, hs:96, hbp:48,
                               vv:480, vfp:10, vs:2, vbp:33, hp:1'b0, vp:1'b0, dly:2};
    localparam cfg_t CFG_B = '{div:1, hv:8, hfp:2, hs:2, hbp:2,
                               vv:4, vfp:1, vs:1, vbp:1, hp:1'b1, vp:1'b0, dly:0};

    logic reloj = 1'b0;
    logic resetM;
    logic enable;

    logic [9:0] qh_a, qv_a;
    logic hs_a, vs_a, hon_a, von_a, pt_a, ls_a, fs_a, hs2_a, vs2_a, vid2_a;
    logic [3:0] qh_b, qv_b;
    logic hs_b, vs_b, hon_b, von_b, pt_b, ls_b, fs_b, hs2_b, vs2_b, vid2_b;

    int checks_total  = 0;
    int checks_passed = 0;

    int cnt_a = 0, cnt_b = 0;
    bit lt_a = 1'b0, lt_b = 1'b0;

    vga_sync_gen u_a (
        .reloj(reloj), .resetM(resetM), .enable(enable),
        .Qh(qh_a), .Qv(qv_a), .H_Sync(hs_a), .V_Sync(vs_a), .H_ON(hon_a), .V_ON(von_a),
        .pix_tick(pt_a), .line_start(ls_a), .frame_start(fs_a),
        .H_Sync2(hs2_a), .V_Sync2(vs2_a), .video_on2(vid2_a)
    );

    vga_sync_gen #(
        .H_VIS(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b0), .CW(4), .DLY(0)
    ) u_b (
        .reloj(reloj), .resetM(resetM), .enable(enable),
        .Qh(qh_b), .Qv(qv_b), .H_Sync(hs_b), .V_Sync(vs_b), .H_ON(hon_b), .V_ON(von_b),
        .pix_tick(pt_b), .line_start(ls_b), .frame_start(fs_b),
        .H_Sync2(hs2_b), .V_Sync2(vs2_b), .video_on2(vid2_b)
    );

    always #5 reloj = ~reloj;

    task automatic chk(input string name, input int act, input int exp);
        checks_total++;
        if (act == exp) checks_passed++;
        else $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int htot(cfg_t c); return c.hv + c.hfp + c.hs + c.hbp; endfunction
    function automatic int vtot(cfg_t c); return c.vv + c.vfp + c.vs + c.vbp; endfunction
    function automatic int qh_at(cfg_t c, int t); return t % htot(c); endfunction
    function automatic int qv_at(cfg_t c, int t); return (t / htot(c)) % vtot(c); endfunction
    function automatic bit hs_at(cfg_t c, int t);
        int q = qh_at(c, t);
        return (q >= c.hv + c.hfp && q < c.hv + c.hfp + c.hs) ? c.hp : !c.hp;
    endfunction
    function automatic bit vs_at(cfg_t c, int t);
        int q = qv_at(c, t);
        return (q >= c.vv + c.vfp && q < c.vv + c.vfp + c.vs) ? c.vp : !c.vp;
    endfunction
    function automatic bit vid_at(cfg_t c, int t);
        return (qh_at(c, t) < c.hv) && (qv_at(c, t) < c.vv);
    endfunction

    // Compares one instance against the model derived from its enabled-clock count.
    task automatic check_dut(input string nm, input cfg_t c, input int cnt, input bit lt,
                             input bit en, input bit rn, input int aqh, input int aqv,
                             input bit ahs, input bit avs, input bit ahon, input bit avon,
                             input bit apt, input bit als, input bit afs,
                             input bit ahs2, input bit avs2, input bit avid2);
        int t = cnt / c.div;
        int d = t - c.dly;
        int eqh = qh_at(c, t);
        int eqv = qv_at(c, t);
        bit ept = rn && en && ((cnt % c.div) == c.div - 1);
        bit els = rn && en && lt && (eqh == 0);
        bit efs = els && (eqv == 0);
        chk({nm, ".Qh"}, aqh, eqh);
        chk({nm, ".Qv"}, aqv, eqv);
        chk({nm, ".H_Sync"}, int'(ahs), int'(hs_at(c, t)));
        chk({nm, ".V_Sync"}, int'(avs), int'(vs_at(c, t)));
        chk({nm, ".H_ON"}, int'(ahon), int'(eqh < c.hv));
        chk({nm, ".V_ON"}, int'(avon), int'(eqv < c.vv));
        chk({nm, ".pix_tick"}, int'(apt), int'(ept));
        chk({nm, ".line_start"}, int'(als), int'(els));
        chk({nm, ".frame_start"}, int'(afs), int'(efs));
        chk({nm, ".H_Sync2"}, int'(ahs2), (d >= 0) ? int'(hs_at(c, d)) : int'(!c.hp));
        chk({nm, ".V_Sync2"}, int'(avs2), (d >= 0) ? int'(vs_at(c, d)) : int'(!c.vp));
        chk({nm, ".video_on2"}, int'(avid2), (d >= 0) ? int'(vid_at(c, d)) : 0);
    endtask

    // Model state: enabled clocks since reset, and whether the last edge was a pixel edge.
    always @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            cnt_a <= 0; lt_a <= 1'b0; cnt_b <= 0; lt_b <= 1'b0;
        end else if (enable) begin
            lt_a  <= ((cnt_a % CFG_A.div) == CFG_A.div - 1);
            cnt_a <= cnt_a + 1;
            lt_b  <= ((cnt_b % CFG_B.div) == CFG_B.div - 1);
            cnt_b <= cnt_b + 1;
        end else begin
            lt_a <= 1'b0; lt_b <= 1'b0;
        end
    end

    // Every-cycle comparison on the inactive clock edge.
    always @(negedge reloj) begin
        check_dut("a", CFG_A, cnt_a, lt_a, enable, resetM, int'(qh_a), int'(qv_a),
                  hs_a, vs_a, hon_a, von_a, pt_a, ls_a, fs_a, hs2_a, vs2_a, vid2_a);
        check_dut("b", CFG_B, cnt_b, lt_b, enable, resetM, int'(qh_b), int'(qv_b),
                  hs_b, vs_b, hon_b, von_b, pt_b, ls_b, fs_b, hs2_b, vs2_b, vid2_b);
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge reloj); #2; end
    endtask

    // Waits (bounded) for the next pixel edge of instance a; returns 2 after it.
    task automatic next_tick_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge reloj);
            if (pt_a) begin ok = 1'b1; break; end
        end
        @(posedge reloj); #2;
    endtask

    initial begin
        int guard, hs_low, hon_hi, ls_n, quiet, timeouts;
        int b_hs, b_vs, b_fs, b_ls, b_pt;
        bit ok;
        resetM = 1'b0;
        enable = 1'b1;
        cyc(3);
        // Reset state, literal
        chk("rst.Qh", int'(qh_a), 0);
        chk("rst.H_Sync_a", int'(hs_a), 1);
        chk("rst.H_ON_a", int'(hon_a), 1);
        chk("rst.video_on2_a", int'(vid2_a), 0);
        chk("rst.pix_tick_b", int'(pt_b), 0);
        chk("rst.H_Sync_b", int'(hs_b), 0);
        resetM = 1'b1;
        cyc(2);
        chk("first_tick.early", int'(pt_a), 0);
        cyc(1);
        chk("first_tick.on_4th", int'(pt_a), 1);
        cyc(1);
        chk("first_tick.Qh1", int'(qh_a), 1);
        chk("first_tick.no_ls", int'(ls_a), 0);

        // Freeze at Qh=100 for 50 clocks
        guard = 0;
        while (int'(qh_a) != 100 && guard < 2000) begin cyc(1); guard++; end
        chk("reach_qh100", int'(qh_a), 100);
        enable = 1'b0;
        quiet = 0;
        repeat (50) begin
            cyc(1);
            if (pt_a || ls_a || fs_a || pt_b) quiet++;
        end
        chk("freeze.Qh", int'(qh_a), 100);
        chk("freeze.no_pulses", quiet, 0);
        enable = 1'b1;
        cyc(4);
        chk("resume.Qh101", int'(qh_a), 101);

        // One full line of instance a
        hs_low = 0; hon_hi = 0; ls_n = 0; timeouts = 0;
        for (int k = 0; k < 800; k++) begin
            next_tick_a(ok);
            if (!ok) timeouts++;
            if (!hs_a) hs_low++;
            if (hon_a) hon_hi++;
            if (ls_a) ls_n++;
        end
        chk("line.tick_timeouts", timeouts, 0);
        chk("line.hsync_low_ticks", hs_low, 96);
        chk("line.h_on_ticks", hon_hi, 640);
        chk("line.line_starts", ls_n, 1);

        // One full frame of instance b (continuous ticks)
        b_hs = 0; b_vs = 0; b_fs = 0; b_ls = 0; b_pt = 0;
        repeat (98) begin
            @(negedge reloj);
            if (hs_b) b_hs++;
            if (!vs_b) b_vs++;
            if (fs_b) b_fs++;
            if (ls_b) b_ls++;
            if (pt_b) b_pt++;
        end
        chk("b.hsync_high", b_hs, 14);
        chk("b.vsync_low", b_vs, 14);
        chk("b.frame_starts", b_fs, 1);
        chk("b.line_starts", b_ls, 7);
        chk("b.pix_ticks", b_pt, 98);
        guard = 0;
        while (int'(qh_b) != 10 && guard < 20) begin @(negedge reloj); guard++; end
        chk("b.Qh10_seen", int'(qh_b), 10);
        chk("b.Qh10_hsync", int'(hs_b), 1);

        // Asynchronous reset mid-line
        guard = 0;
        while (int'(qh_a) != 300 && guard < 4000) begin cyc(1); guard++; end
        chk("reach_qh300", int'(qh_a), 300);
        chk("reach_qv1", int'(qv_a), 1);
        resetM = 1'b0;
        #1;
        chk("arst.Qh", int'(qh_a), 0);
        chk("arst.Qv", int'(qv_a), 0);
        chk("arst.H_Sync", int'(hs_a), 1);
        chk("arst.V_Sync", int'(vs_a), 1);
        chk("arst.H_ON", int'(hon_a), 1);
        chk("arst.V_ON", int'(von_a), 1);
        chk("arst.pix_tick", int'(pt_a), 0);
        chk("arst.H_Sync2", int'(hs2_a), 1);
        chk("arst.video_on2", int'(vid2_a), 0);
        chk("arst.b_Qh", int'(qh_b), 0);
        cyc(3);
        resetM = 1'b1;
        cyc(4);
        chk("restart.Qh", int'(qh_a), 1);
        chk("restart.Qv", int'(qv_a), 0);
        cyc(300);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
